// File: rtl/nanEye_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nanEye_pkg
// Purpose  : Shared types and helpers for the multi-page DPRAM write controller.
// Revision : 1.0 - initial release
// ============================================================================
package nanEye_pkg;

  localparam int C_PAGE_W_DFLT = 2;
  localparam int NPAGES        = 1 << C_PAGE_W_DFLT;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WRITE      = 2'd1,
    SKIP       = 2'd2
  } state_t;

  // Page index lands above the pixel index; the caller truncates to its bus width.
  function automatic logic [31:0] page_addr(input logic [31:0] pg,
                                            input logic [31:0] pix,
                                            input int          addr_w);
    return (pg << addr_w) | pix;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_wr_ctrl_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : dpram_wr_ctrl_mp_if
// Purpose  : Deserializer/reader strobes in, DPRAM write port and status out.
// Revision : 1.0 - initial release
// ============================================================================
interface dpram_wr_ctrl_mp_if #(
  parameter int C_ADDR_W = 9,
  parameter int C_PAGE_W = 2,
  parameter int C_LCNT_W = 9
);
  logic                         PULSE;
  logic                         PIXEL_ERROR;
  logic                         LINE_SYNC;
  logic                         FRAME_SYNC;
  logic                         RD_PAGE_DONE;
  logic [C_PAGE_W+C_ADDR_W-1:0] DPRAM_WR_ADDR;
  logic                         DPRAM_WE;
  logic [C_PAGE_W-1:0]          DPRAM_RD_PAGE;
  logic                         LINE_FINISHED;
  logic [C_ADDR_W:0]            LINE_LENGTH;
  logic                         LINE_ERR;
  logic                         OVERRUN;
  logic [C_PAGE_W:0]            PAGES_USED;
  logic [C_LCNT_W-1:0]          LINE_CNT;
  logic                         FRAME_DONE;

  modport slave (
    input  PULSE, PIXEL_ERROR, LINE_SYNC, FRAME_SYNC, RD_PAGE_DONE,
    output DPRAM_WR_ADDR, DPRAM_WE, DPRAM_RD_PAGE, LINE_FINISHED, LINE_LENGTH,
           LINE_ERR, OVERRUN, PAGES_USED, LINE_CNT, FRAME_DONE
  );

  modport master (
    output PULSE, PIXEL_ERROR, LINE_SYNC, FRAME_SYNC, RD_PAGE_DONE,
    input  DPRAM_WR_ADDR, DPRAM_WE, DPRAM_RD_PAGE, LINE_FINISHED, LINE_LENGTH,
           LINE_ERR, OVERRUN, PAGES_USED, LINE_CNT, FRAME_DONE
  );
endinterface
`default_nettype wire

// File: rtl/page_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : page_ring_ctrl
// Purpose  : Write/read page pointers and occupancy of the DPRAM page ring.
// Revision : 1.0 - initial release
// ============================================================================
module page_ring_ctrl #(
  parameter int C_PAGE_W = 2
) (
  input  wire logic                CLOCK,
  input  wire logic                RESET_N,
  input  wire logic                commit,
  input  wire logic                page_release,
  input  wire logic                flush,
  output logic [C_PAGE_W-1:0]      wr_pg,
  output logic [C_PAGE_W-1:0]      cmt_pg,
  output logic [C_PAGE_W:0]        used,
  output logic                     full
);

  localparam logic [C_PAGE_W:0] RING_SZ = (C_PAGE_W+1)'(1 << C_PAGE_W);

  logic [C_PAGE_W-1:0] r_wr_pg;
  logic [C_PAGE_W-1:0] r_rd_pg;
  logic [C_PAGE_W-1:0] r_cmt_pg;
  logic [C_PAGE_W:0]   r_used;
  logic                w_rel;

  // A release with nothing committed is meaningless and dropped.
  assign w_rel = page_release && (r_used != '0);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_pg  <= '0;
      r_rd_pg  <= '0;
      r_cmt_pg <= '0;
      r_used   <= '0;
    end else if (flush) begin
      r_wr_pg  <= '0;
      r_rd_pg  <= '0;
      r_cmt_pg <= '0;
      r_used   <= '0;
    end else begin
      if (commit) begin
        r_wr_pg  <= r_wr_pg + 1'b1;
        r_cmt_pg <= r_wr_pg;
      end
      if (w_rel) begin
        r_rd_pg <= r_rd_pg + 1'b1;
      end
      case ({commit, w_rel})
        2'b10:   r_used <= r_used + 1'b1;
        2'b01:   r_used <= r_used - 1'b1;
        default: r_used <= r_used;
      endcase
    end
  end

  assign wr_pg  = r_wr_pg;
  assign cmt_pg = r_cmt_pg;
  assign used   = r_used;
  assign full   = (r_used == RING_SZ);

endmodule
`default_nettype wire

// File: rtl/dpram_wr_ctrl_mp.sv
`default_nettype none
// ============================================================================
// Module   : dpram_wr_ctrl_mp
// Purpose  : Writes received lines into a ring of DPRAM pages, reports status.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_wr_ctrl_mp #(
  parameter int C_ADDR_W      = 9,
  parameter int C_PAGE_W      = 2,
  parameter int C_LINE_PIXELS = 250,
  parameter int C_LINES       = 250,
  parameter int C_LCNT_W      = 9
) (
  input  wire logic          CLOCK,
  input  wire logic          RESET_N,
  dpram_wr_ctrl_mp_if.slave  bus
);
  import nanEye_pkg::*;

  localparam logic [C_ADDR_W-1:0] PIX_MAX   = '1;
  localparam logic [C_LCNT_W-1:0] LCNT_MAX  = '1;
  localparam logic [C_ADDR_W:0]   LINE_PIX  = (C_ADDR_W+1)'(C_LINE_PIXELS);
  localparam logic [C_LCNT_W-1:0] LINES_FRM = C_LCNT_W'(C_LINES);

  state_t                       r_state, w_state_nxt;
  logic [C_ADDR_W-1:0]          r_pix_cnt;
  logic                         r_pix_err;
  logic                         r_we;
  logic [C_PAGE_W+C_ADDR_W-1:0] r_addr;
  logic                         r_lf;
  logic [C_ADDR_W:0]            r_len;
  logic                         r_lerr;
  logic                         r_ovr;
  logic [C_LCNT_W-1:0]          r_lcnt;
  logic                         r_fd;

  logic w_wr_pix, w_drop_sat, w_commit, w_line_clr, w_ovr_set, w_err_now;
  logic [C_ADDR_W:0]            w_len;
  logic [C_LCNT_W-1:0]          w_lcnt_nxt;
  logic [C_PAGE_W+C_ADDR_W-1:0] w_addr;
  logic [C_PAGE_W-1:0]          w_wr_pg, w_cmt_pg;
  logic [C_PAGE_W:0]            w_used;
  logic                         w_full;

  page_ring_ctrl #(.C_PAGE_W(C_PAGE_W)) u_ring (
    .CLOCK        (CLOCK),
    .RESET_N      (RESET_N),
    .commit       (w_commit),
    .page_release (bus.RD_PAGE_DONE),
    .flush        (bus.FRAME_SYNC),
    .wr_pg        (w_wr_pg),
    .cmt_pg       (w_cmt_pg),
    .used         (w_used),
    .full         (w_full)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) r_state <= WAIT_FRAME;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_pix    = 1'b0;
    w_drop_sat  = 1'b0;
    w_commit    = 1'b0;
    w_line_clr  = 1'b0;
    w_ovr_set   = 1'b0;
    if (bus.FRAME_SYNC) begin
      w_state_nxt = WRITE;
    end else begin
      case (r_state)
        WAIT_FRAME: w_state_nxt = WAIT_FRAME;
        WRITE: begin
          // A full ring can only be met at line start, so nothing is lost here.
          if (bus.PULSE && w_full) begin
            w_ovr_set = 1'b1;
            if (bus.LINE_SYNC) w_line_clr  = 1'b1;
            else               w_state_nxt = SKIP;
          end else begin
            if (bus.PULSE) begin
              if (r_pix_cnt == PIX_MAX) w_drop_sat = 1'b1;
              else                      w_wr_pix   = 1'b1;
            end
            if (bus.LINE_SYNC && ((r_pix_cnt != '0) || bus.PULSE)) w_commit = 1'b1;
          end
        end
        SKIP: begin
          if (bus.LINE_SYNC) begin
            w_state_nxt = WRITE;
            w_line_clr  = 1'b1;
          end
        end
        default: w_state_nxt = WAIT_FRAME;
      endcase
    end
  end

  assign w_err_now  = r_pix_err | (w_wr_pix & bus.PIXEL_ERROR) | w_drop_sat;
  assign w_len      = {1'b0, r_pix_cnt} + {{C_ADDR_W{1'b0}}, w_wr_pix};
  assign w_lcnt_nxt = (r_lcnt == LCNT_MAX) ? r_lcnt : r_lcnt + 1'b1;
  assign w_addr     = (C_PAGE_W+C_ADDR_W)'(page_addr(32'(w_wr_pg), 32'(r_pix_cnt), C_ADDR_W));

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pix_cnt <= '0;
      r_pix_err <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_lf      <= 1'b0;
      r_len     <= '0;
      r_lerr    <= 1'b0;
      r_ovr     <= 1'b0;
      r_lcnt    <= '0;
      r_fd      <= 1'b0;
    end else begin
      r_we <= w_wr_pix;
      r_lf <= w_commit;
      r_fd <= 1'b0;
      if (w_wr_pix) r_addr <= w_addr;
      if (bus.FRAME_SYNC) begin
        r_pix_cnt <= '0;
        r_pix_err <= 1'b0;
        r_lcnt    <= '0;
        r_ovr     <= 1'b0;
      end else begin
        if (w_ovr_set) r_ovr <= 1'b1;
        if (w_commit) begin
          r_len     <= w_len;
          r_lerr    <= (w_len != LINE_PIX) | w_err_now;
          r_lcnt    <= w_lcnt_nxt;
          r_fd      <= (w_lcnt_nxt == LINES_FRM);
          r_pix_cnt <= '0;
          r_pix_err <= 1'b0;
        end else if (w_line_clr) begin
          r_pix_cnt <= '0;
          r_pix_err <= 1'b0;
        end else begin
          if (w_wr_pix) r_pix_cnt <= r_pix_cnt + 1'b1;
          r_pix_err <= w_err_now;
        end
      end
    end
  end

  assign bus.DPRAM_WR_ADDR = r_addr;
  assign bus.DPRAM_WE      = r_we;
  assign bus.DPRAM_RD_PAGE = w_cmt_pg;
  assign bus.LINE_FINISHED = r_lf;
  assign bus.LINE_LENGTH   = r_len;
  assign bus.LINE_ERR      = r_lerr;
  assign bus.OVERRUN       = r_ovr;
  assign bus.PAGES_USED    = w_used;
  assign bus.LINE_CNT      = r_lcnt;
  assign bus.FRAME_DONE    = r_fd;

endmodule
`default_nettype wire

// File: tb/tb_dpram_wr_ctrl_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_wr_ctrl_mp
// Purpose  : Directed self-checking bench for the multi-page write controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_wr_ctrl_mp;
  import nanEye_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpram_wr_ctrl_mp_if #(.C_ADDR_W(9), .C_PAGE_W(2), .C_LCNT_W(9)) bus ();

  dpram_wr_ctrl_mp #(
    .C_ADDR_W(9), .C_PAGE_W(2), .C_LINE_PIXELS(250), .C_LINES(250), .C_LCNT_W(9)
  ) dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int m_pg  = 0;
  int m_pix = 0;
  int we_cnt = 0;
  int lf_cnt = 0;
  int fd_cnt = 0;
  int base;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Every write must land at the next pixel of the page the bench expects.
  always @(negedge clk) begin
    if (bus.DPRAM_WE === 1'b1) begin
      check("wr_addr", int'(bus.DPRAM_WR_ADDR), m_pg * 512 + m_pix);
      m_pix++;
      we_cnt++;
    end
    if (bus.LINE_FINISHED === 1'b1) lf_cnt++;
    if (bus.FRAME_DONE === 1'b1)    fd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic err);
    bus.PULSE = 1'b1; bus.PIXEL_ERROR = err;
    tick();
    bus.PULSE = 1'b0; bus.PIXEL_ERROR = 1'b0;
  endtask

  task automatic line_end();
    bus.LINE_SYNC = 1'b1;
    tick();
    bus.LINE_SYNC = 1'b0;
  endtask

  task automatic frame_start();
    bus.FRAME_SYNC = 1'b1;
    tick();
    bus.FRAME_SYNC = 1'b0;
  endtask

  task automatic page_done();
    bus.RD_PAGE_DONE = 1'b1;
    tick();
    bus.RD_PAGE_DONE = 1'b0;
  endtask

  task automatic start_line(input int pg);
    m_pg  = pg;
    m_pix = 0;
  endtask

  task automatic line(input int pg, input int n, input int err_at);
    start_line(pg);
    for (int i = 0; i < n; i++) pixel(i == err_at);
    line_end();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.PULSE = 1'b0; bus.PIXEL_ERROR = 1'b0; bus.LINE_SYNC = 1'b0;
    bus.FRAME_SYNC = 1'b0; bus.RD_PAGE_DONE = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we",    int'(bus.DPRAM_WE), 0);
    check("rst_addr",  int'(bus.DPRAM_WR_ADDR), 0);
    check("rst_used",  int'(bus.PAGES_USED), 0);
    check("rst_lcnt",  int'(bus.LINE_CNT), 0);
    check("rst_flags", int'({bus.LINE_FINISHED, bus.LINE_ERR, bus.OVERRUN, bus.FRAME_DONE}), 0);
    check("rst_len",   int'(bus.LINE_LENGTH), 0);
    rst_n = 1'b1;
    tick();

    // Before the first frame start, pixels and line ends are ignored
    pixel(1'b0);
    line_end();
    tick();
    check("wait_we", we_cnt, 0);
    check("wait_lf", lf_cnt, 0);

    // One full line into page 0
    frame_start();
    line(0, 250, -1);
    check("t1_lf",   int'(bus.LINE_FINISHED), 1);
    check("t1_rdpg", int'(bus.DPRAM_RD_PAGE), 0);
    check("t1_len",  int'(bus.LINE_LENGTH), 250);
    check("t1_err",  int'(bus.LINE_ERR), 0);
    check("t1_used", int'(bus.PAGES_USED), 1);
    check("t1_lcnt", int'(bus.LINE_CNT), 1);
    check("t1_wes",  we_cnt, 250);

    // Fill the ring, then overrun
    frame_start();
    for (int p = 0; p < 4; p++) begin
      line(p, 250, -1);
      check("t2_lf",   int'(bus.LINE_FINISHED), 1);
      check("t2_rdpg", int'(bus.DPRAM_RD_PAGE), p);
    end
    check("t2_used4", int'(bus.PAGES_USED), 4);
    base = we_cnt;
    line(0, 250, -1);
    check("t2_skip_lf",  int'(bus.LINE_FINISHED), 0);
    tick();
    check("t2_skip_we",  we_cnt - base, 0);
    check("t2_ovr",      int'(bus.OVERRUN), 1);
    check("t2_skip_used", int'(bus.PAGES_USED), 4);
    page_done();
    check("t2_rel_used", int'(bus.PAGES_USED), 3);
    line(0, 250, -1);
    check("t2_l6_lf",   int'(bus.LINE_FINISHED), 1);
    check("t2_l6_rdpg", int'(bus.DPRAM_RD_PAGE), 0);
    check("t2_l6_ovr",  int'(bus.OVERRUN), 1);
    check("t2_l6_used", int'(bus.PAGES_USED), 4);
    check("t2_l6_lcnt", int'(bus.LINE_CNT), 5);

    // Short line with a bad pixel
    page_done();
    line(1, 249, 100);
    check("t3_len",  int'(bus.LINE_LENGTH), 249);
    check("t3_err",  int'(bus.LINE_ERR), 1);
    check("t3_rdpg", int'(bus.DPRAM_RD_PAGE), 1);

    // Last pixel coincides with the line end
    page_done();
    start_line(2);
    for (int i = 0; i < 249; i++) pixel(1'b0);
    bus.PULSE = 1'b1; bus.LINE_SYNC = 1'b1;
    tick();
    bus.PULSE = 1'b0; bus.LINE_SYNC = 1'b0;
    check("t4_we",  int'(bus.DPRAM_WE), 1);
    check("t4_lf",  int'(bus.LINE_FINISHED), 1);
    check("t4_len", int'(bus.LINE_LENGTH), 250);
    check("t4_err", int'(bus.LINE_ERR), 0);
    line_end();
    check("t4_empty_lf",   int'(bus.LINE_FINISHED), 0);
    check("t4_empty_used", int'(bus.PAGES_USED), 4);

    // Commit and release in the same cycle
    page_done();
    start_line(3);
    for (int i = 0; i < 250; i++) pixel(1'b0);
    bus.LINE_SYNC = 1'b1; bus.RD_PAGE_DONE = 1'b1;
    tick();
    bus.LINE_SYNC = 1'b0; bus.RD_PAGE_DONE = 1'b0;
    check("t4b_lf",   int'(bus.LINE_FINISHED), 1);
    check("t4b_used", int'(bus.PAGES_USED), 3);
    check("t4b_rdpg", int'(bus.DPRAM_RD_PAGE), 3);
    check("t4b_lcnt", int'(bus.LINE_CNT), 8);

    // Frame start in the middle of a line
    page_done();
    check("t5_used2", int'(bus.PAGES_USED), 2);
    start_line(0);
    for (int i = 0; i < 100; i++) pixel(1'b0);
    base = lf_cnt;
    frame_start();
    tick();
    check("t5_lf",   lf_cnt - base, 0);
    check("t5_used", int'(bus.PAGES_USED), 0);
    check("t5_lcnt", int'(bus.LINE_CNT), 0);
    check("t5_ovr",  int'(bus.OVERRUN), 0);
    line(0, 1, -1);
    check("t5_len",  int'(bus.LINE_LENGTH), 1);
    check("t5_err",  int'(bus.LINE_ERR), 1);
    check("t5_lcnt1", int'(bus.LINE_CNT), 1);

    // Whole frame with a release after every line
    frame_start();
    base = fd_cnt;
    for (int l = 0; l < 250; l++) begin
      line(l % 4, 250, -1);
      if (l == 248) check("t6_fd_early", int'(bus.FRAME_DONE), 0);
      if (l == 249) check("t6_fd_pulse", int'(bus.FRAME_DONE), 1);
      page_done();
    end
    tick();
    check("t6_fd_cnt", fd_cnt - base, 1);
    check("t6_lcnt",   int'(bus.LINE_CNT), 250);
    check("t6_used",   int'(bus.PAGES_USED), 0);

    // Asynchronous reset mid-line
    start_line(2);
    for (int i = 0; i < 50; i++) pixel(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_we",   int'(bus.DPRAM_WE), 0);
    check("t6_rst_addr", int'(bus.DPRAM_WR_ADDR), 0);
    check("t6_rst_lcnt", int'(bus.LINE_CNT), 0);
    check("t6_rst_len",  int'(bus.LINE_LENGTH), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    base = we_cnt;
    pixel(1'b0);
    pixel(1'b0);
    line_end();
    tick();
    check("t6_post_we", we_cnt - base, 0);
    check("t6_post_lf", int'(bus.LINE_FINISHED), 0);
    frame_start();
    start_line(0);
    pixel(1'b0);
    tick();
    check("t6_fs_we", we_cnt - base, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
